// File: rtl/id_operand_stage.sv
// id_operand_stage: register-file operand fetch with EX/MEM/WB bypass,
// load-use stall detection and a valid/ready ID/EX pipeline register.
module id_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic                  in_rs1_used,
  input  logic                  in_rs2_used,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_rd_wr_en,
  input  logic                  in_is_load,
  input  logic [XLEN-1:0]       in_pc,
  output logic [REG_ADDR_W-1:0] rd_reg_1,
  output logic [REG_ADDR_W-1:0] rd_reg_2,
  input  logic [XLEN-1:0]       rd_data_1,
  input  logic [XLEN-1:0]       rd_data_2,
  input  logic                  ex_valid,
  input  logic                  ex_wr_en,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       ex_result,
  input  logic                  mem_valid,
  input  logic                  mem_wr_en,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  wb_wr_en,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_rs1_data,
  output logic [XLEN-1:0]       out_rs2_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_rd_wr_en,
  output logic                  out_is_load,
  output logic [XLEN-1:0]       out_pc,
  output logic [CNT_W-1:0]      stall_cycles
);
  logic                  r_valid;
  logic [XLEN-1:0]       r_rs1_data;
  logic [XLEN-1:0]       r_rs2_data;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_rd_wr_en;
  logic                  r_is_load;
  logic [XLEN-1:0]       r_pc;
  logic [CNT_W-1:0]      r_stall;
  logic                  w_ex_fwd;
  logic                  w_mem_fwd;
  logic [XLEN-1:0]       w_op1;
  logic [XLEN-1:0]       w_op2;
  logic                  w_hazard;
  logic                  w_accept;
  logic                  w_free;

  assign rd_reg_1 = in_rs1;
  assign rd_reg_2 = in_rs2;
  // A load in EX has no data yet, so it is a stall source, never a bypass source.
  assign w_ex_fwd  = ex_valid && ex_wr_en && !ex_is_load;
  assign w_mem_fwd = mem_valid && mem_wr_en;
  // Index 0 is tested first, so a zero destination can never forward.
  assign w_op1 = (in_rs1 == '0) ? '0 :
                 (w_ex_fwd && ex_rd == in_rs1) ? ex_result :
                 (w_mem_fwd && mem_rd == in_rs1) ? mem_data :
                 (wb_wr_en && wb_rd == in_rs1) ? wb_data : rd_data_1;
  assign w_op2 = (in_rs2 == '0) ? '0 :
                 (w_ex_fwd && ex_rd == in_rs2) ? ex_result :
                 (w_mem_fwd && mem_rd == in_rs2) ? mem_data :
                 (wb_wr_en && wb_rd == in_rs2) ? wb_data : rd_data_2;
  assign w_hazard = ex_valid && ex_is_load && ex_wr_en && ex_rd != '0 &&
                    ((in_rs1_used && ex_rd == in_rs1) || (in_rs2_used && ex_rd == in_rs2));
  assign w_free   = !r_valid || out_ready;
  assign in_ready = !flush && !w_hazard && w_free;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rd       <= '0;
      r_rd_wr_en <= 1'b0;
      r_is_load  <= 1'b0;
      r_pc       <= '0;
      r_stall    <= '0;
    end else begin
      if (in_valid && w_hazard && !flush && r_stall != '1)
        r_stall <= r_stall + 1'b1;
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid    <= 1'b1;
        r_rs1_data <= w_op1;
        r_rs2_data <= w_op2;
        r_rd       <= in_rd;
        r_rd_wr_en <= in_rd_wr_en;
        r_is_load  <= in_is_load;
        r_pc       <= in_pc;
      end else if (w_free) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_valid;
  assign out_rs1_data = r_rs1_data;
  assign out_rs2_data = r_rs2_data;
  assign out_rd       = r_rd;
  assign out_rd_wr_en = r_rd_wr_en;
  assign out_is_load  = r_is_load;
  assign out_pc       = r_pc;
  assign stall_cycles = r_stall;
endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode-side operand fetch stage, directly upstream of the EX stage and wrapped around the register file's two combinational read ports.
- Drives the read addresses and resolves operands by bypassing from EX, MEM and WB.
- Detects load-use hazards and stalls for them.
- Registers the resolved operands into the ID/EX pipeline register under a valid/ready handshake, with flush support.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width (32 architectural registers, x0 hardwired zero).
- CNT_W, 32, stall-cycle counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1, in_rs2  in  REG_ADDR_W  source register indices
- in_rs1_used, in_rs2_used  in  1  source actually consumed
- in_rd  in  REG_ADDR_W  destination index
- in_rd_wr_en  in  1  instruction writes rd
- in_is_load  in  1  instruction is a load
- in_pc  in  XLEN  instruction PC
- rd_reg_1, rd_reg_2  out  REG_ADDR_W  register file read addresses
- rd_data_1, rd_data_2  in  XLEN  register file read data (combinational)
- ex_valid, ex_wr_en, ex_is_load  in  1  EX-stage instruction status
- ex_rd  in  REG_ADDR_W  EX destination
- ex_result  in  XLEN  EX ALU result
- mem_valid, mem_wr_en  in  1  MEM-stage status
- mem_rd  in  REG_ADDR_W  MEM destination
- mem_data  in  XLEN  MEM final result, load data included
- wb_wr_en  in  1  WB write enable, same signal as the register file wr_en
- wb_rd  in  REG_ADDR_W  WB destination
- wb_data  in  XLEN  WB write data
- flush  in  1  kill stage contents
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  EX accepts
- out_rs1_data, out_rs2_data  out  XLEN  resolved operands
- out_rd  out  REG_ADDR_W  destination index
- out_rd_wr_en, out_is_load  out  1  passed-through controls
- out_pc  out  XLEN  passed-through PC
- stall_cycles  out  CNT_W  load-use stall counter

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: out_valid=0; every other out_* = 0; stall_cycles=0. Reset beats flush and all other inputs.
- Read addresses: rd_reg_1=in_rs1 and rd_reg_2=in_rs2, combinational, always driven.
- Operand resolution, per source, first match wins:
  - index 0 -> 0;
  - ex_valid&&ex_wr_en&&!ex_is_load&&ex_rd==rs -> ex_result;
  - mem_valid&&mem_wr_en&&mem_rd==rs -> mem_data;
  - wb_wr_en&&wb_rd==rs -> wb_data;
  - else rd_data_n.
  - A destination of 0 never forwards.
- Load-use hazard: ex_valid && ex_is_load && ex_wr_en && ex_rd!=0 && ((in_rs1_used && ex_rd==in_rs1) || (in_rs2_used && ex_rd==in_rs2)).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready): next cycle out_valid=1 and all out_* take the resolved or passed-through values.
- Hazard with (!out_valid || out_ready): insert a bubble (out_valid<=0, data outputs held). stall_cycles += 1 when in_valid && hazard, saturating at all-ones.
- Backpressure (out_valid && !out_ready): all out_* hold their values exactly. Forwarding values are not re-sampled.
- No accept and no backpressure: out_valid<=0 once EX consumes the current instruction.
- flush=1: out_valid<=0 next cycle; the in_* instruction is not accepted (in_ready=0). stall_cycles is not incremented.
- Latency: one cycle from accept to out_valid. Throughput of one instruction per cycle when hazard-free and out_ready=1.
- Simultaneous hazard and backpressure: hold the outputs; the stall counter still increments.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_rs1_data=0, stall_cycles=0; after release, the first accept yields out_valid=1 after 1 cycle.
- Forward priority: rs1=5; ex (rd=5, 0xAAAA0000), mem (rd=5, 0x11), wb (rd=5, 0x22), rd_data_1=0x33 -> out_rs1_data=0xAAAA0000. Drop ex -> 0x11. Drop mem -> 0x22. Drop wb -> 0x33.
- x0: rs1=rs2=0 with ex/mem/wb all writing rd=0, data 0xFFFFFFFF -> both out data=0.
- Load-use: ex load rd=7, in_rs2=7, in_rs2_used=1 -> in_ready=0, bubble (out_valid=0), stall_cycles=1. Next cycle ex_valid=0, mem rd=7, data 0x1234 -> accepted, out_rs2_data=0x1234. Same case with in_rs2_used=0 -> no stall.
- Backpressure: accept pc=0x100, then out_ready=0 for 3 cycles while wb writes rs1 -> out_pc=0x100 and out_rs1_data unchanged; in_ready=0 throughout.
- Flush: flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0, input not consumed (in_ready=0 in the flush cycle).
